// File: rtl/iterative_muldiv.sv
// iterative_muldiv: radix-2 iterative multiplier / divider.
//
// One shift-add (multiply) or restoring-subtract (divide) step per clock,
// followed by a single sign-correction cycle. Signed operations run on
// magnitudes and fix the sign at the end.
//
// Configuration macro: MULDIV_DIVIDE_EN
//   defined   -> DIV / DIVU are implemented (restoring divide datapath).
//   undefined -> no divide datapath; DIV / DIVU finish after one cycle with
//                hi = lo = 0 and div_by_zero = 0.
//
// Handshake: start is a request pulse, accepted on a rising edge where the
// FSM is in IDLE or DONE (busy low); op/a/b are captured on that edge and may
// change afterwards. busy is high from the accepting edge until the result is
// written; done is a one-cycle pulse in which hi/lo/div_by_zero are valid.
// A start that arrives while busy is high is dropped, not queued.

module iterative_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int            CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Control state
    logic [1:0]    state;
    logic [CW-1:0] step_cnt;

    // Datapath registers. For a multiply, acc_lo starts as the multiplier and
    // m_reg holds the multiplicand; for a divide, acc_lo starts as the
    // dividend (becoming the quotient) and m_reg holds the divisor.
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] m_reg;
    logic             is_div;
    logic             neg_a;
    logic             neg_b;
`ifdef MULDIV_DIVIDE_EN
    logic             short_q;   // divide by zero: skip CALC, report a / all ones
`endif

    // Operand decode at the acceptance edge
    logic             accept;
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic             short_path;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] load_lo;
    logic [WIDTH-1:0] load_m;

    // Per-step datapath
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
`ifdef MULDIV_DIVIDE_EN
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
`endif

    // Sign correction
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic               fix_dbz;

    // Decode the request: magnitudes for signed ops, which path to take.
    always_comb begin
        accept     = start && ((state == S_IDLE) || (state == S_DONE));
        op_signed  = ~op[0];
        a_neg      = op_signed & a[WIDTH-1];
        b_neg      = op_signed & b[WIDTH-1];
        a_mag      = a_neg ? -a : a;
        b_mag      = b_neg ? -b : b;
        load_lo    = b_mag;
        load_m     = a_mag;
        short_path = 1'b0;
        if (op[1]) begin
`ifdef MULDIV_DIVIDE_EN
            short_path = (b == '0);
            // On divide-by-zero the raw dividend is parked in acc_lo so FIX
            // can return it unchanged as the remainder.
            load_lo    = short_path ? a : a_mag;
            load_m     = b_mag;
`else
            short_path = 1'b1;
`endif
        end
    end

    // One radix-2 step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_reg} : '0);
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
`ifdef MULDIV_DIVIDE_EN
        // The partial remainder stays below the divisor, so a negative trial
        // always means the shifted value fits in WIDTH bits.
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_trial = div_shift - {1'b0, m_reg};
        if (is_div) begin
            if (div_trial[WIDTH]) begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end else begin
                step_hi = div_trial[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end
        end
`endif
    end

    // Final result: negate the product, quotient or remainder as needed.
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = (neg_a ^ neg_b) ? -prod : prod;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        fix_dbz  = 1'b0;
        if (is_div) begin
`ifdef MULDIV_DIVIDE_EN
            if (short_q) begin
                fix_hi  = acc_lo;
                fix_lo  = '1;
                fix_dbz = 1'b1;
            end else begin
                // Quotient truncates toward zero; remainder follows the
                // dividend. MIN / -1 wraps back to MIN with remainder 0.
                fix_lo = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
                fix_hi = neg_a ? -acc_hi : acc_hi;
            end
`else
            fix_hi = '0;
            fix_lo = '0;
`endif
        end
    end

    // FSM: IDLE/DONE accept, CALC steps WIDTH times, FIX writes the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            step_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state    <= short_path ? S_FIX : S_CALC;
                        step_cnt <= '0;
                    end else begin
                        state    <= S_IDLE;
                    end
                end
                S_CALC: begin
                    step_cnt <= step_cnt + CW'(1);
                    if (step_cnt == LAST_STEP) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath: capture operands on accept, iterate in CALC, publish in FIX.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_hi      <= '0;
            acc_lo      <= '0;
            m_reg       <= '0;
            is_div      <= 1'b0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
            short_q     <= 1'b0;
`endif
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            acc_hi      <= '0;
            acc_lo      <= load_lo;
            m_reg       <= load_m;
            is_div      <= op[1];
            neg_a       <= a_neg;
            neg_b       <= b_neg;
`ifdef MULDIV_DIVIDE_EN
            short_q     <= short_path;
`endif
            div_by_zero <= 1'b0;
        end else if (state == S_CALC) begin
            acc_hi      <= step_hi;
            acc_lo      <= step_lo;
        end else if (state == S_FIX) begin
            hi          <= fix_hi;
            lo          <= fix_lo;
            div_by_zero <= fix_dbz;
        end
    end

    assign busy      = (state == S_CALC) || (state == S_FIX);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_iterative_muldiv.sv
// tb_iterative_muldiv: table-driven vectors plus hand-written multi-cycle
// sequences for iterative_muldiv (WIDTH=32). Expected results go into a
// queue when a request is driven and are compared when done pulses.
// Expectations follow MULDIV_DIVIDE_EN when it is defined for the build.

module tb_iterative_muldiv;

    localparam int W  = 32;
    localparam int EW = 2 * W + 1;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULU = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_DIVU = 2'b11;

`ifdef MULDIV_DIVIDE_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;
    logic [1:0]   dbg_state;

    iterative_muldiv #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .div_by_zero(div_by_zero),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int errors   = 0;
    int busy_cnt = 0;
    int t0       = 0;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    logic [EW-1:0] mon_e;
    string         mon_nm;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
        string        name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: count busy cycles, pop and compare on every done pulse.
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                mon_e  = exp_q.pop_front();
                mon_nm = name_q.pop_front();
                check({mon_nm, "_lo"},  64'(lo),          64'(mon_e[W-1:0]));
                check({mon_nm, "_hi"},  64'(hi),          64'(mon_e[2*W-1:W]));
                check({mon_nm, "_dbz"}, 64'(div_by_zero), 64'(mon_e[EW-1]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; the following posedge is the acceptance edge.
    task automatic send(input logic [1:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz,
                        input string nm);
        start    = 1'b1;
        op       = o;
        a        = xa;
        b        = xb;
        busy_cnt = 0;
        exp_q.push_back({edbz, ehi, elo});
        name_q.push_back(nm);
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        a     = $urandom;
        b     = $urandom;
        t0    = cyc;
    endtask

    task automatic wait_done(input string nm, input int exp_lat);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done in 200 cycles expected done", nm);
        end else begin
            check({nm, "_latency"}, 64'(cyc - t0), 64'(exp_lat));
            check({nm, "_busy"},    64'(busy_cnt), 64'(exp_lat));
        end
    endtask

    // Table entries carry the divide-enabled results; a build without the
    // divide datapath expects zeros and a one-cycle turnaround instead.
    task automatic add_vec(input logic [1:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                           input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz,
                           input string nm);
        vec_t v;
        v.op = o; v.a = xa; v.b = xb; v.hi = ehi; v.lo = elo; v.dbz = edbz; v.name = nm;
        v.lat = W + 1;
        if (o[1]) begin
            if (!DIV_EN) begin
                v.hi = '0; v.lo = '0; v.dbz = 1'b0; v.lat = 1;
            end else if (xb == '0) begin
                v.lat = 1;
            end
        end
        vecs.push_back(v);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int dcount;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);

        check("reset_busy",  64'(busy),        64'd0);
        check("reset_done",  64'(done),        64'd0);
        check("reset_hi",    64'(hi),          64'd0);
        check("reset_lo",    64'(lo),          64'd0);
        check("reset_dbz",   64'(div_by_zero), 64'd0);
        check("reset_state", 64'(dbg_state),   64'd0);
        reset = 1'b0;
        @(negedge clk);

        //       op       a             b             hi            lo            dbz
        add_vec(OP_MUL,  32'd6,        32'd7,        32'h00000000, 32'h0000002A, 1'b0, "mul_6x7");
        add_vec(OP_MUL,  32'hFFFFFFFA, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, "mul_m6x7");
        add_vec(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "mulu_max");
        add_vec(OP_MUL,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mul_min_min");
        add_vec(OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, "mul_m1_m1");
        add_vec(OP_MULU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, "mulu_shift");
        add_vec(OP_MUL,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, "mul_max_min");
        add_vec(OP_MULU, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, 1'b0, "mulu_zero");
        add_vec(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7_2");
        add_vec(OP_DIVU, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, "divu_100_7");
        add_vec(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_min_m1");
        add_vec(OP_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, "div_7_m2");
        add_vec(OP_DIVU, 32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999, 1'b0, "divu_max_10");
        add_vec(OP_DIV,  32'd9,        32'd3,        32'h00000000, 32'h00000003, 1'b0, "div_9_3");
        add_vec(OP_DIVU, 32'd3,        32'd10,       32'h00000003, 32'h00000000, 1'b0, "divu_small");
        add_vec(OP_DIVU, 32'h80000000, 32'd0,        32'h80000000, 32'hFFFFFFFF, 1'b1, "divu_by0");

        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].name);
            wait_done(vecs[i].name, vecs[i].lat);
            @(negedge clk);
            check({vecs[i].name, "_done_pulse"}, 64'(done),      64'd0);
            check({vecs[i].name, "_to_idle"},    64'(dbg_state), 64'd0);
        end

        // Back-to-back: second request issued on the done cycle, no bubble.
        send(OP_MUL, 32'hFFFFFFFA, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, "b2b_first");
        wait_done("b2b_first", W + 1);
        send(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "b2b_second");
        check("b2b_busy_after_accept", 64'(busy), 64'd1);
        check("b2b_done_after_accept", 64'(done), 64'd0);
        wait_done("b2b_second", W + 1);
        @(negedge clk);

        // Divide by zero, flag holds in IDLE, next accepted start clears it.
        send(OP_DIV, 32'd5, 32'd0, DIV_EN ? 32'd5 : 32'd0, DIV_EN ? 32'hFFFFFFFF : 32'd0,
             DIV_EN, "div_5_by0");
        wait_done("div_5_by0", 1);
        @(negedge clk);
        check("dbz_hold", 64'(div_by_zero), 64'(DIV_EN));
        send(OP_MUL, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, "mul_after_dbz");
        check("dbz_clear", 64'(div_by_zero), 64'd0);
        wait_done("mul_after_dbz", W + 1);
        @(negedge clk);

        // Start during CALC (sampled at edge 5) must be ignored.
        send(OP_MUL, 32'd6, 32'd7, 32'd0, 32'h2A, 1'b0, "ignore_start");
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = OP_MULU;
        a     = 32'd100;
        b     = 32'd100;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_start", W + 1);
        @(negedge clk);

        // Reset sampled at edge 10 of a multiply discards it.
        send(OP_MUL, 32'd11, 32'd13, 32'd0, 32'd143, 1'b0, "reset_mid");
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_busy",  64'(busy),      64'd0);
        check("midreset_done",  64'(done),      64'd0);
        check("midreset_hi",    64'(hi),        64'd0);
        check("midreset_lo",    64'(lo),        64'd0);
        check("midreset_state", 64'(dbg_state), 64'd0);
        exp_q.delete();
        name_q.delete();
        reset  = 1'b0;
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        check("midreset_no_done", 64'(dcount), 64'd0);

        // Recovery after reset.
        send(OP_MUL, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, "mul_recover");
        wait_done("mul_recover", W + 1);
        @(negedge clk);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/iterative_muldiv.md
ITERATIVE_MULDIV -- requirements
Module: iterative_muldiv

Interface
REQ-001 Parameter WIDTH, default 32: operand width; legal values 8, 16, 32, 64.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; operands and op are sampled when accepted.
REQ-005 op  input  2  00 MUL (signed), 01 MULU, 10 DIV (signed), 11 DIVU.
REQ-006 a  input  WIDTH  multiplicand / dividend.
REQ-007 b  input  WIDTH  multiplier / divisor.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; hi/lo/div_by_zero are valid from this cycle.
REQ-010 hi  output  WIDTH  upper product half / remainder.
REQ-011 lo  output  WIDTH  lower product half / quotient.
REQ-012 div_by_zero  output  1  set with done when a divide had b==0; cleared at the next accepted start.

Function
REQ-013 FSM states: IDLE, CALC, FIX, DONE; start is accepted only in IDLE or DONE; start in CALC/FIX is ignored.
REQ-014 Acceptance edge (edge 0): latch |a|, |b| (signed ops) or raw a, b (unsigned ops), latch signs and op, clear the step counter, enter CALC.
REQ-015 CALC: one radix-2 step per edge (shift-add multiply / restoring divide); after the WIDTH-th step (edge WIDTH), enter FIX.
REQ-016 FIX (edge WIDTH+1): apply sign correction, write hi/lo, enter DONE; done high for exactly that one cycle; busy high after edges 0..WIDTH.
REQ-017 DONE returns to IDLE on the next edge unless start is asserted (back-to-back accept, no bubble); hi/lo hold until the next FIX.
REQ-018 Multiply: {hi,lo} = full 2*WIDTH-bit product; signed product is negated if the operand signs differ.
REQ-019 Divide: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
REQ-020 Divide with b==0: edge 0 goes directly to FIX; done after edge 1; lo = all ones, hi = a, div_by_zero = 1.
REQ-021 Signed DIV of MIN by -1: lo = MIN, hi = 0, div_by_zero = 0, normal latency.

Reset
REQ-022 reset takes priority over start at any state, including mid-CALC: next state IDLE; busy, done, div_by_zero = 0; hi = lo = 0; counter = 0.
REQ-023 The operation in progress at reset is discarded; no done pulse is produced for it.

Configuration
REQ-024 Macro MULDIV_DIVIDE_EN: when defined, DIV/DIVU are implemented per REQ-019..021.
REQ-025 Without MULDIV_DIVIDE_EN, no divide datapath exists; op 10/11 go edge 0 -> FIX, done after edge 1, hi = lo = 0, div_by_zero = 0.

Verification (WIDTH=32, MULDIV_DIVIDE_EN defined unless stated)
REQ-026 MUL a=6, b=7 -> done after edge 33; lo=0x0000002A, hi=0; busy high for exactly 33 cycles.
REQ-027 MUL a=-6, b=7 -> lo=0xFFFFFFD6, hi=0xFFFFFFFF; MULU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, issued back-to-back on the done cycle with no idle cycle between operations.
REQ-028 DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100, b=7 -> lo=14, hi=2.
REQ-029 DIV a=5, b=0 -> done after edge 1, div_by_zero=1, lo=0xFFFFFFFF, hi=5; next MUL clears div_by_zero.
REQ-030 reset asserted at edge 10 of a MUL -> busy=0, hi=lo=0 next cycle, no done; start asserted at edge 5 of a MUL is ignored (result unchanged).
REQ-031 Macro undefined: DIV a=9, b=3 -> done after edge 1, hi=lo=0, div_by_zero=0.
